// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Fetch sequencer between a combinational instruction memory and decode.
//   Owns the byte PC, drives the imem word address, registers each fetched
//   instruction together with its PC into the IF/ID stage, and hands it to
//   decode. Handles redirects (branch/jump), decode back-pressure, halt and
//   resume.
//
//   Handshake: id_valid/id_ready follow strict valid/ready semantics. A
//   transfer happens on a rising edge where id_valid=1 and id_ready=1. While
//   id_valid=1 and id_ready=0 the stage holds id_inst/id_pc unchanged. A
//   redirect may withdraw id_valid (flush) regardless of id_ready.
//
//   Optional feature (macro FETCH_LOADER_EN): program-loader write port that
//   takes ownership of imem whenever the sequencer is not in RUN.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             1-cycle pulse, IDLE/HALT -> RUN
//   halt              RUN -> HALT
//   imem_addr         word address to imem (pc[ADDR_W+1:2])
//   imem_data         same-cycle read data from imem
//   id_valid/id_ready IF/ID handshake toward decode
//   id_inst, id_pc    registered instruction and its byte PC
//   redirect_valid/pc branch/jump redirect (RUN only)
//   busy              state == RUN
//   err               sticky misaligned-redirect flag
//   state             debug view of the FSM: IDLE=0, RUN=1, HALT=2
//   ld_* / imem_w*    loader port (FETCH_LOADER_EN only)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int                ADDR_W   = 10,
   parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_inst,
   output logic [ADDR_W+1:0] id_pc,
   input  logic              redirect_valid,
   input  logic [ADDR_W+1:0] redirect_pc,
   output logic              busy,
   output logic              err,
   output logic [1:0]        state
`ifdef FETCH_LOADER_EN
   ,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   output logic              ld_gnt,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata
`endif
);

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_run  = 2'd1,
      st_halt = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W+1:0]   pc_q, pc_d;
   logic                id_valid_q, id_valid_d;
   logic [31:0]         id_inst_q, id_inst_d;
   logic [ADDR_W+1:0]   id_pc_q, id_pc_d;
   logic                err_q, err_d;

   logic                advance;
   logic                start_ok;
   logic                consume;

   // The loader owns imem outside RUN; while it holds the grant, start is
   // ignored so the core never fetches a half-written program.
`ifdef FETCH_LOADER_EN
   assign ld_gnt     = ld_req && (state_q != st_run);
   assign imem_we    = ld_gnt;
   assign imem_waddr = ld_addr;
   assign imem_wdata = ld_data;
   assign start_ok   = start && !err_q && !ld_gnt;
`else
   assign start_ok   = start && !err_q;
`endif

   assign advance   = !id_valid_q || id_ready;
   assign consume   = id_valid_q && id_ready;

   assign imem_addr = pc_q[ADDR_W+1:2];
   assign id_valid  = id_valid_q;
   assign id_inst   = id_inst_q;
   assign id_pc     = id_pc_q;
   assign busy      = (state_q == st_run);
   assign err       = err_q;
   assign state     = state_q;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= st_idle;
         pc_q       <= RESET_PC;
         id_valid_q <= 1'b0;
         id_inst_q  <= '0;
         id_pc_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_valid_q <= id_valid_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         err_q      <= err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state / datapath
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_valid_d = id_valid_q;
      id_inst_d  = id_inst_q;
      id_pc_d    = id_pc_q;
      err_d      = err_q;

      unique case (state_q)
         st_idle: begin
            if (consume)  id_valid_d = 1'b0;
            if (start_ok) state_d    = st_run;
         end

         st_run: begin
            if (redirect_valid) begin
               // Redirect beats advance and stall; the stage is flushed
               // even if decode is not ready.
               id_valid_d = 1'b0;
               if (redirect_pc[1:0] != 2'b00) begin
                  // Misaligned target: keep pc, latch the error, stop.
                  err_d   = 1'b1;
                  state_d = st_halt;
               end else begin
                  pc_d = redirect_pc;
                  if (halt) state_d = st_halt;
               end
            end else begin
               if (advance) begin
                  id_inst_d  = imem_data;
                  id_pc_d    = pc_q;
                  id_valid_d = 1'b1;
                  pc_d       = pc_q + (ADDR_W+2)'(4);  // wraps modulo 2^(ADDR_W+2)
               end
               if (halt) state_d = st_halt;
            end
         end

         st_halt: begin
            // No new fetch; a pending instruction drains normally so that
            // resume continues at the held pc without gaps or repeats.
            if (consume)  id_valid_d = 1'b0;
            if (start_ok) state_d    = st_run;
         end

         default: begin
            state_d    = st_idle;
            id_valid_d = 1'b0;
         end
      endcase
   end

endmodule
